dac_bank_sequencer: RTL
=======================

// Module: dac_bank_sequencer
// PURPOSE
//  Parametrised successor to the fixed nine-channel DAC drive path.
//  Pops 32-bit command words from the USB read FIFO and decodes channel, voltage, delay and mode.
//  Holds a shadow and an active value per channel and drives NUM_CH three-wire serial DACs
//  (word clock, bit clock, data) from one shared bit-tick generator.
//  Adds delayed, coalesced and broadcast/simultaneous updates. Sits between readusb and the GPIO_1 DAC pins.
// PARAMETERS
//  NUM_CH    9   number of DAC channels, numbered 1..NUM_CH; channel 0 is reserved
//  VBITS     16  DAC word width; fixed at 16 by the command format, shifted MSB first
//  SCLK_DIV  2   bitclk cycles per serial tick; must be >= 1; dac_sclk period = 2*SCLK_DIV cycles
//  TM_UNIT   64  bitclk cycles per delay unit of the tm field
// PORTS
//  bitclk     in   1         system clock; all logic on the rising edge
//  reset      in   1         asynchronous, active-high
//  cmd_data   in   32        FIFO read data: [15:0]=v, [21:16]=ch, [27:22]=tm, [31:28]=mode
//  cmd_empty  in   1         FIFO empty flag (rdempty)
//  cmd_rd     out  1         FIFO pop strobe; one cycle per word
//  dac_lrck   out  NUM_CH    per-channel word clock; bit i-1 drives channel i
//  dac_sclk   out  NUM_CH    per-channel bit clock
//  dac_sdata  out  NUM_CH    per-channel serial data
//  busy       out  NUM_CH    channel has a frame pending or in flight
//  cmd_err    out  1         one-cycle pulse when a command is discarded
// BEHAVIOUR
//  Reset values, applied immediately on reset assertion:
//   - cmd_rd=0, cmd_err=0, busy=0, dac_sclk=0, dac_lrck=all 1, dac_sdata=0.
//   - shadow/active/pending cleared, FSM in IDLE, tick and delay counters cleared.
//   - Reset mid-frame aborts the shift. The DAC may latch a partial word; software reissues after reset.
//  Command FSM (one command at a time, strictly in FIFO order):
//   - IDLE: if !cmd_empty, assert cmd_rd for 1 cycle and go to FETCH.
//   - FETCH: register cmd_data (FIFO data is valid the cycle after cmd_rd) and go to DECODE.
//   - DECODE: validate mode and ch.
//       - Invalid: pulse cmd_err, go to IDLE. Invalid means mode>3, or ch==0 or ch>NUM_CH when mode is 0 or 1.
//       - Valid with tm==0: go to ISSUE.
//       - Valid with tm!=0: go to WAIT.
//   - WAIT: count tm*TM_UNIT cycles, then go to ISSUE. The queue is blocked meanwhile.
//   - ISSUE: apply the command for exactly 1 cycle, then go to IDLE.
//   - Fastest command-to-command spacing: 4 cycles.
//  Modes, applied in ISSUE:
//   - 0: shadow[ch]<=v; nothing transmitted.
//   - 1: shadow[ch]<=v; pending[ch]<=1.
//   - 2: pending<=1 for all channels; v and ch ignored. Resends current shadows simultaneously.
//   - 3: all shadows<=v; all pending<=1.
//  Tick generator: free-running; one tick every SCLK_DIV cycles while not in reset.
//  Frame engine (per channel; all engines share tick boundaries):
//   - Frame start: on a tick where the engine is idle and pending=1, do active<=shadow and pending<=0.
//   - Data phase: lrck low; VBITS sclk periods.
//       - sdata changes on the falling sclk tick and the MSB is driven at the start tick.
//       - The DAC samples sdata on rising sclk.
//   - Latch phase: one more sclk period with lrck high. The DAC latches on the lrck rise.
//   - Frame length is 2*(VBITS+1) ticks.
//   - Idle between frames: sclk=0, lrck=1, sdata=0.
//  Coalescing: a mode 1/3 issue on a channel mid-frame updates the shadow and sets pending.
//   - The current frame completes unchanged.
//   - The next frame carries the latest shadow. Multiple issues during one frame yield one frame.
//  Simultaneity: mode 2/3 on all-idle channels starts every frame on the same tick (identical lrck edges).
//  ISSUE coincident with a frame start on the same channel: the frame uses the pre-ISSUE shadow; pending stays 1.
//  busy[i-1] = pending[i] | in-frame[i].
// TESTING
//  - reset held, then released with FIFO empty -> all outputs at reset values; cmd_rd never asserts.
//  - SCLK_DIV=2; word 0x1003_A5C3 (mode1, ch3, tm0) -> ch3 shifts 1010_0101_1100_0011 MSB first.
//    lrck3 rises after 16 sclk periods; frame is 68 cycles; all other channels stay idle.
//  - words mode0 ch1 0x1111, mode0 ch2 0x2222, then mode2 -> ch1 and ch2 start on the same tick
//    with 0x1111 and 0x2222; the remaining channels resend 0x0000.
//  - mode1 ch5 0x0001, then mode1 ch5 0x00FF and mode1 ch5 0x0F0F both issued mid-frame ->
//    exactly two frames on ch5 (0x0001 then 0x0F0F).
//  - ch=0, ch=10 (NUM_CH=9) and mode=7 -> three cmd_err pulses; no DAC activity;
//    the following valid word is still executed.
//  - tm=3 with TM_UNIT=64 -> ISSUE occurs 192 cycles after WAIT entry.
//    Reset asserted mid-WAIT -> no frame; all outputs at reset values.

Source files
------------

// File: rtl/dac_bank_sequencer.sv
// Command-driven sequencer for NUM_CH three-wire serial DACs: pops 32-bit words from the
// USB read FIFO, applies them after an optional delay and shifts frames on a shared tick.
module dac_bank_sequencer #(
  parameter int NUM_CH   = 9,
  parameter int VBITS    = 16,
  parameter int SCLK_DIV = 2,
  parameter int TM_UNIT  = 64
) (
  input  logic              i_bitclk,
  input  logic              i_reset,
  input  logic [31:0]       i_cmd_data,
  input  logic              i_cmd_empty,
  output logic              o_cmd_rd,
  output logic [NUM_CH-1:0] o_dac_lrck,
  output logic [NUM_CH-1:0] o_dac_sclk,
  output logic [NUM_CH-1:0] o_dac_sdata,
  output logic [NUM_CH-1:0] o_busy,
  output logic              o_cmd_err
);

  localparam int TICK_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int FRAME_TICKS = 2 * (VBITS + 1);
  localparam int PH_W        = $clog2(FRAME_TICKS);
  localparam int BIT_W       = $clog2(VBITS);
  localparam int WAIT_W      = $clog2(63 * TM_UNIT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_WAIT   = 3'd3,
    S_ISSUE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_cmd;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_cmd_err;
  logic                w_cmd_rd;
  logic                w_issue;
  logic                w_err;
  logic                w_valid;
  logic                w_ch_ok;
  logic [3:0]          w_mode;
  logic [5:0]          w_tm;
  logic [5:0]          w_ch;
  logic [VBITS-1:0]    w_v;

  logic [TICK_W-1:0]   r_tick_cnt;
  logic                w_tick;

  logic [VBITS-1:0]    r_shadow [NUM_CH];
  logic [VBITS-1:0]    r_active [NUM_CH];
  logic [PH_W-1:0]     r_phase  [NUM_CH];
  logic [NUM_CH-1:0]   r_pending;
  logic [NUM_CH-1:0]   r_in_frame;
  logic [NUM_CH-1:0]   r_lrck;
  logic [NUM_CH-1:0]   r_sclk;
  logic [NUM_CH-1:0]   r_sdata;

  logic [PH_W-1:0]     w_phase_nxt [NUM_CH];
  logic [BIT_W-1:0]    w_bit_idx   [NUM_CH];
  logic [NUM_CH-1:0]   w_sdata_nxt;
  logic [NUM_CH-1:0]   w_sel;
  logic [NUM_CH-1:0]   w_wr_shadow;
  logic [NUM_CH-1:0]   w_wr_pend;
  logic [NUM_CH-1:0]   w_start;

  assign w_mode = r_cmd[31:28];
  assign w_tm   = r_cmd[27:22];
  assign w_ch   = r_cmd[21:16];
  assign w_v    = r_cmd[15:0];

  // Command legality: channel 0 is reserved, only modes 0..3 exist.
  always_comb begin
    w_ch_ok = (w_ch != 6'd0) && (int'(w_ch) <= NUM_CH);
    case (w_mode)
      4'd0, 4'd1: w_valid = w_ch_ok;
      4'd2, 4'd3: w_valid = 1'b1;
      default:    w_valid = 1'b0;
    endcase
  end

  // Command FSM next-state and strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_rd    = 1'b0;
    w_issue     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_cmd_empty) begin
          w_cmd_rd    = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (!w_valid) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tm == 6'd0) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, fetched command word and delay counter.
  always_ff @(posedge i_bitclk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cmd      <= 32'd0;
      r_wait_cnt <= '0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd_err <= w_err;
      if (r_state == S_FETCH) begin
        r_cmd <= i_cmd_data;
      end
      // Loaded with N-1 so WAIT lasts exactly tm*TM_UNIT cycles.
      if (r_state == S_DECODE) begin
        r_wait_cnt <= WAIT_W'(w_tm) * WAIT_W'(TM_UNIT) - WAIT_W'(1);
      end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
      end
    end
  end

  // Shared free-running serial tick.
  always_ff @(posedge i_bitclk or posedge i_reset) begin
    if (i_reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  assign w_tick = (r_tick_cnt == TICK_W'(SCLK_DIV - 1));

  // Per-channel issue decode, frame-start qualification and next serial bit.
  always_comb begin
    w_wr_shadow = '0;
    w_wr_pend   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel[i]       = (int'(w_ch) == (i + 1));
      w_start[i]     = w_tick && !r_in_frame[i] && r_pending[i];
      w_phase_nxt[i] = r_phase[i] + PH_W'(1);
      w_bit_idx[i]   = BIT_W'(VBITS - 1) - w_phase_nxt[i][BIT_W:1];
      if (w_phase_nxt[i] < PH_W'(2 * VBITS)) begin
        w_sdata_nxt[i] = r_active[i][w_bit_idx[i]];
      end else begin
        w_sdata_nxt[i] = 1'b0;
      end
    end
    if (w_issue) begin
      case (w_mode)
        4'd0: w_wr_shadow = w_sel;
        4'd1: begin
          w_wr_shadow = w_sel;
          w_wr_pend   = w_sel;
        end
        4'd2: w_wr_pend = '1;
        4'd3: begin
          w_wr_shadow = '1;
          w_wr_pend   = '1;
        end
        default: w_wr_pend = '0;
      endcase
    end else begin
      w_wr_pend = '0;
    end
  end

  // Shadow values and pending flags; an ISSUE beats a coincident frame start.
  always_ff @(posedge i_bitclk or posedge i_reset) begin
    if (i_reset) begin
      r_pending <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_shadow[i]) begin
          r_shadow[i] <= w_v;
        end
        if (w_wr_pend[i]) begin
          r_pending[i] <= 1'b1;
        end else if (w_start[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Frame engines: phase 0..2*VBITS-1 data with lrck low, last two phases latch with lrck high.
  always_ff @(posedge i_bitclk or posedge i_reset) begin
    if (i_reset) begin
      r_in_frame <= '0;
      r_lrck     <= '1;
      r_sclk     <= '0;
      r_sdata    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_active[i] <= '0;
        r_phase[i]  <= '0;
      end
    end else if (w_tick) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_start[i]) begin
          r_active[i]   <= r_shadow[i];
          r_in_frame[i] <= 1'b1;
          r_phase[i]    <= '0;
          r_lrck[i]     <= 1'b0;
          r_sclk[i]     <= 1'b0;
          r_sdata[i]    <= r_shadow[i][VBITS-1];
        end else if (r_in_frame[i]) begin
          if (r_phase[i] == PH_W'(FRAME_TICKS - 1)) begin
            r_in_frame[i] <= 1'b0;
            r_phase[i]    <= '0;
            r_lrck[i]     <= 1'b1;
            r_sclk[i]     <= 1'b0;
            r_sdata[i]    <= 1'b0;
          end else begin
            r_phase[i] <= w_phase_nxt[i];
            r_sclk[i]  <= w_phase_nxt[i][0];
            r_lrck[i]  <= (w_phase_nxt[i] >= PH_W'(2 * VBITS));
            r_sdata[i] <= w_sdata_nxt[i];
          end
        end
      end
    end
  end

  assign o_cmd_rd    = w_cmd_rd;
  assign o_cmd_err   = r_cmd_err;
  assign o_dac_lrck  = r_lrck;
  assign o_dac_sclk  = r_sclk;
  assign o_dac_sdata = r_sdata;
  assign o_busy      = r_pending | r_in_frame;

endmodule
